// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin L2 arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // Index width that never collapses to zero bits, even for a single port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_pkg_rr_picker.sv
// Combinational winner selection: first requester at or after the pointer.
// ARB_FIXED_PRIORITY_EN switches to lowest-index-wins and drops the pointer input.
module rr_picker
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDW       = 1
) (
  input  logic [NUM_PORTS-1:0] i_req,
`ifndef ARB_FIXED_PRIORITY_EN
  input  logic [IDW-1:0]       i_ptr,
`endif
  output logic [IDW-1:0]       o_winner,
  output logic                 o_valid
);

  always_comb begin : pick
    int w_off;
    int w_best;
    o_winner = '0;
    o_valid  = 1'b0;
    w_off    = 0;
    w_best   = NUM_PORTS;
    for (int j = 0; j < NUM_PORTS; j++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      w_off = j;
`else
      // Distance from the pointer going upward with wrap; smallest distance wins.
      w_off = j - int'(i_ptr);
      if (w_off < 0) w_off = w_off + NUM_PORTS;
`endif
      if (i_req[j] && (w_off < w_best)) begin
        w_best   = w_off;
        o_winner = IDW'(j);
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter_rr.sv
// N-port round-robin arbiter onto a single L2 port; captured request held for the
// whole L2 transaction. Define ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration.
module arbiter_rr
  import arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int IDW        = clog2_min1(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            port_read,
  input  logic [NUM_PORTS-1:0]            port_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0] port_wdata,
  output logic [NUM_PORTS-1:0]            port_resp,
  output logic [LINE_WIDTH-1:0]           port_rdata,
  input  logic                            L2_resp,
  input  logic [LINE_WIDTH-1:0]           L2_rdata,
  output logic                            L2_read,
  output logic                            L2_write,
  output logic [ADDR_WIDTH-1:0]           L2_addr,
  output logic [LINE_WIDTH-1:0]           L2_wdata,
  output logic [IDW-1:0]                  grant_id,
  output logic                            busy
);

  arb_state_t            r_state;
  arb_state_t            w_state_next;
  logic                  r_rd;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [IDW-1:0]        r_grant;

  logic [NUM_PORTS-1:0]  w_req;
  logic [IDW-1:0]        w_winner;
  logic                  w_valid;
  logic                  w_take;
  logic                  w_resp_fire;
  logic                  w_sel_rd;
  logic                  w_sel_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [LINE_WIDTH-1:0] w_sel_wdata;

  assign w_req = port_read | port_write;

`ifdef ARB_FIXED_PRIORITY_EN
  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDW       (IDW)
  ) u_picker (
    .i_req    (w_req),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );
`else
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] w_ptr_next;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDW       (IDW)
  ) u_picker (
    .i_req    (w_req),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  assign w_ptr_next = (int'(w_winner) == NUM_PORTS - 1) ? '0 : w_winner + IDW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_take) begin
      r_rr_ptr <= w_ptr_next;
    end
  end
`endif

  // Select the winning port's request fields; compare-based to keep any port count legal.
  always_comb begin
    w_sel_rd    = 1'b0;
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (w_winner == IDW'(j)) begin
        w_sel_rd    = port_read[j];
        w_sel_wr    = port_write[j];
        w_sel_addr  = port_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = port_wdata[j*LINE_WIDTH +: LINE_WIDTH];
      end
    end
  end

  assign w_take      = (r_state == IDLE) && w_valid;
  assign w_resp_fire = (r_state == BUSY) && L2_resp;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_state_next = BUSY;
      BUSY:    if (L2_resp) w_state_next = GAP;
      GAP:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_take) begin
        r_rd    <= w_sel_rd;
        r_wr    <= w_sel_wr;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_grant <= w_winner;
      end
    end
  end

  // L2 side sees only the captured request, and only while BUSY.
  assign L2_read    = (r_state == BUSY) && r_rd;
  assign L2_write   = (r_state == BUSY) && r_wr;
  assign L2_addr    = r_addr;
  assign L2_wdata   = r_wdata;
  assign grant_id   = r_grant;
  assign busy       = (r_state != IDLE);
  assign port_rdata = w_resp_fire ? L2_rdata : '0;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
      assign port_resp[gi] = w_resp_fire && (r_grant == IDW'(gi));
    end
  endgenerate

  always @(posedge clk) begin
    if (!rst && w_take) begin
      assert (!(w_sel_rd && w_sel_wr))
      else $error("arbiter_rr: port %0d has read and write high together", w_winner);
    end
  end

endmodule

// File: tb/tb_arbiter_rr.sv
// Directed self-checking bench for arbiter_rr with four ports.
module tb_arbiter_rr;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int LW  = 256;
  localparam int IDW = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    port_read;
  logic [N-1:0]    port_write;
  logic [N*AW-1:0] port_addr;
  logic [N*LW-1:0] port_wdata;
  logic [N-1:0]    port_resp;
  logic [LW-1:0]   port_rdata;
  logic            L2_resp;
  logic [LW-1:0]   L2_rdata;
  logic            L2_read;
  logic            L2_write;
  logic [AW-1:0]   L2_addr;
  logic [LW-1:0]   L2_wdata;
  logic [IDW-1:0]  grant_id;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  arbiter_rr #(
    .NUM_PORTS  (N),
    .ADDR_WIDTH (AW),
    .LINE_WIDTH (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .port_read  (port_read),
    .port_write (port_write),
    .port_addr  (port_addr),
    .port_wdata (port_wdata),
    .port_resp  (port_resp),
    .port_rdata (port_rdata),
    .L2_resp    (L2_resp),
    .L2_rdata   (L2_rdata),
    .L2_read    (L2_read),
    .L2_write   (L2_write),
    .L2_addr    (L2_addr),
    .L2_wdata   (L2_wdata),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic int exp_grant(input int t);
`ifdef ARB_FIXED_PRIORITY_EN
    return 0;
`else
    return t % N;
`endif
  endfunction

  initial begin
    logic [N-1:0]  exp_resp;
    logic [LW-1:0] pat;
    int            g;

    rst        = 1'b1;
    port_read  = '0;
    port_write = '0;
    port_addr  = '0;
    port_wdata = '0;
    L2_resp    = 1'b0;
    L2_rdata   = '0;

    // Reset state
    mid();
    chk("rst_l2_read", L2_read, 0);
    chk("rst_l2_write", L2_write, 0);
    chk("rst_port_resp", port_resp, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_l2_addr", L2_addr, 0);
    chk("rst_port_rdata", port_rdata, 0);
    nxt();
    rst = 1'b0;
    $display("txn reset: state checked");

    // Single read from port 1, L2 answers three cycles in
    nxt();
    port_read[1]          = 1'b1;
    port_addr[1*AW +: AW] = 32'h0000_1000;
    mid();
    chk("single_idle_l2_read", L2_read, 0);
    chk("single_idle_busy", busy, 0);
    nxt();
    mid();
    chk("single_l2_read", L2_read, 1);
    chk("single_l2_addr", L2_addr, 32'h0000_1000);
    chk("single_grant", grant_id, 1);
    chk("single_busy", busy, 1);
    nxt();
    nxt();
    nxt();
    pat      = {32{8'hA5}};
    L2_resp  = 1'b1;
    L2_rdata = pat;
    mid();
    chk("single_port_resp", port_resp, 4'b0010);
    chk("single_port_rdata", port_rdata, pat);
    nxt();
    L2_resp      = 1'b0;
    L2_rdata     = '0;
    port_read[1] = 1'b0;
    mid();
    chk("single_gap_l2_read", L2_read, 0);
    chk("single_gap_busy", busy, 1);
    chk("single_gap_resp", port_resp, 0);
    nxt();
    mid();
    chk("single_idle_after", busy, 0);
    $display("txn single: port 1 read 0x1000 served");

    // Contention: reset pointer, all four ports read continuously
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    for (int i = 0; i < N; i++) port_addr[i*AW +: AW] = 32'(i * 32'h100);
    port_read = 4'hF;
    nxt();
    for (int t = 0; t < 6; t++) begin
      g = exp_grant(t);
      mid();
      chk("cont_grant", grant_id, g);
      chk("cont_l2_addr", L2_addr, 32'(g * 32'h100));
      chk("cont_l2_read", L2_read, 1);
      nxt();
      pat      = {8{32'hC0DE_0000 + 32'(t)}};
      L2_resp  = 1'b1;
      L2_rdata = pat;
      exp_resp = 4'b0001 << g;
      mid();
      chk("cont_port_resp", port_resp, exp_resp);
      chk("cont_port_rdata", port_rdata, pat);
      nxt();
      L2_resp  = 1'b0;
      L2_rdata = '0;
      mid();
      chk("cont_gap_l2_read", L2_read, 0);
      chk("cont_gap_resp", port_resp, 0);
      nxt();
      if (t == 5) port_read = '0;
      mid();
      chk("cont_idle_busy", busy, 0);
      nxt();
      $display("txn contention %0d: grant %0d", t, g);
    end

    // Port 0 write at 0x40; live address change during BUSY must be ignored
    port_write[0]          = 1'b1;
    port_addr[0 +: AW]     = 32'h40;
    port_wdata[0 +: LW]    = {8{32'h1234_5678}};
    nxt();
    mid();
    chk("chg_l2_write", L2_write, 1);
    chk("chg_l2_read", L2_read, 0);
    chk("chg_grant", grant_id, 0);
    chk("chg_l2_addr0", L2_addr, 32'h40);
    chk("chg_l2_wdata0", L2_wdata, {8{32'h1234_5678}});
    nxt();
    port_addr[0 +: AW]  = 32'h80;
    port_wdata[0 +: LW] = '0;
    mid();
    chk("chg_l2_addr1", L2_addr, 32'h40);
    chk("chg_l2_wdata1", L2_wdata, {8{32'h1234_5678}});
    nxt();
    L2_resp = 1'b1;
    mid();
    chk("chg_l2_addr2", L2_addr, 32'h40);
    chk("chg_port_resp", port_resp, 4'b0001);
    nxt();
    L2_resp       = 1'b0;
    port_write[0] = 1'b0;
    mid();
    chk("chg_gap_l2_write", L2_write, 0);
    nxt();
    $display("txn change: port 0 write kept addr 0x40");

    // Async reset mid-transaction on port 3
    port_read[3]          = 1'b1;
    port_addr[3*AW +: AW] = 32'h300;
    nxt();
    mid();
    chk("arst_pre_grant", grant_id, 3);
    chk("arst_pre_l2_read", L2_read, 1);
    nxt();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_l2_read", L2_read, 0);
    chk("arst_busy", busy, 0);
    chk("arst_grant", grant_id, 0);
    chk("arst_l2_addr", L2_addr, 0);
    nxt();
    rst = 1'b0;
    mid();
    chk("arst_idle_busy", busy, 0);
    nxt();
    mid();
    chk("arst_regrant", grant_id, 3);
    chk("arst_regrant_read", L2_read, 1);
    chk("arst_regrant_addr", L2_addr, 32'h300);
    nxt();
    pat      = {16{16'h5A3C}};
    L2_resp  = 1'b1;
    L2_rdata = pat;
    mid();
    chk("arst_port_resp", port_resp, 4'b1000);
    chk("arst_port_rdata", port_rdata, pat);
    nxt();
    L2_resp      = 1'b0;
    L2_rdata     = '0;
    port_read[3] = 1'b0;
    nxt();
    $display("txn async reset: port 3 re-granted");

    // Spurious L2_resp in IDLE while port 2 requests
    port_read[2]          = 1'b1;
    port_addr[2*AW +: AW] = 32'h200;
    pat                   = {32{8'h3C}};
    L2_resp               = 1'b1;
    L2_rdata              = pat;
    mid();
    chk("spur_port_resp", port_resp, 0);
    chk("spur_port_rdata", port_rdata, 0);
    nxt();
    L2_resp  = 1'b0;
    L2_rdata = '0;
    mid();
    chk("spur_grant", grant_id, 2);
    chk("spur_l2_read", L2_read, 1);
    chk("spur_busy_resp", port_resp, 0);
    nxt();
    pat      = {32{8'h96}};
    L2_resp  = 1'b1;
    L2_rdata = pat;
    mid();
    chk("spur_port_resp2", port_resp, 4'b0100);
    chk("spur_port_rdata2", port_rdata, pat);
    nxt();
    L2_resp      = 1'b0;
    L2_rdata     = '0;
    port_read[2] = 1'b0;
    mid();
    chk("spur_gap_busy", busy, 1);
    nxt();
    mid();
    chk("spur_idle_busy", busy, 0);
    $display("txn spurious: ignored in IDLE, port 2 served");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arbiter_rr.md
Name: arbiter_rr

Overview:
- N-port round-robin arbiter between L1-side requesters (I-cache, D-cache, prefetcher, ...) and a single L2 port.
- Generalises the two-port fixed arbiter in three ways: parametrised port count and widths, fair rotation, and a captured request held stable for the whole L2 transaction.
- Sits between the L1 caches and L2. Uses the same level-held read/write and one-cycle resp handshake on both sides.

Parameters:
- NUM_PORTS, 2, number of requester ports (2..8).
- ADDR_WIDTH, 32, address width.
- LINE_WIDTH, 256, cache line width in bits.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- port_read  in  NUM_PORTS  per-port read request, level, held until that port's resp.
- port_write  in  NUM_PORTS  per-port write request, level, held until that port's resp.
- port_addr  in  NUM_PORTS*ADDR_WIDTH  packed addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- port_wdata  in  NUM_PORTS*LINE_WIDTH  packed write lines; port i at [i*LINE_WIDTH +: LINE_WIDTH].
- port_resp  out  NUM_PORTS  one-hot, one-cycle completion pulse to the granted port.
- port_rdata  out  LINE_WIDTH  shared read data; valid only while some port_resp bit is high.
- L2_resp  in  1  L2 completion pulse.
- L2_rdata  in  LINE_WIDTH  L2 read data, valid with L2_resp.
- L2_read  out  1  read request to L2.
- L2_write  out  1  write request to L2.
- L2_addr  out  ADDR_WIDTH  L2 address.
- L2_wdata  out  LINE_WIDTH  L2 write data.
- grant_id  out  $clog2(NUM_PORTS) (min 1)  index of the port currently granted.
- busy  out  1  high in BUSY and GAP states.

Behaviour:
- Reset (async, applies immediately):
  - state = IDLE; rr_ptr = 0; capture registers = 0.
  - Outputs: L2_read = L2_write = 0, port_resp = 0, grant_id = 0, busy = 0; L2_addr, L2_wdata, port_rdata = 0.
- Request of port i: req[i] = port_read[i] | port_write[i].
- States:
  - IDLE:
    - If any req, pick the first requesting port at or after rr_ptr, wrapping modulo NUM_PORTS.
    - Capture that port's read, write, addr and wdata; set grant_id to it; rr_ptr <= winner+1 (wraps NUM_PORTS-1 -> 0); go to BUSY.
    - If no req, stay in IDLE.
  - BUSY:
    - L2_read, L2_write, L2_addr, L2_wdata are driven from the capture registers only, never from live inputs.
    - On L2_resp: port_resp[grant_id] = 1 and port_rdata = L2_rdata combinationally in the same cycle; next state GAP.
  - GAP:
    - One cycle with L2_read = L2_write = 0, then IDLE.
    - Guarantees L2 sees the request deassert, and lets the served requester drop its request before re-arbitration.
- Latency:
  - Request high at edge n (state IDLE) -> L2_read/L2_write high from cycle n+1.
  - L2_resp in cycle k -> port_resp in cycle k.
  - Earliest next grant is sampled at k+2.
  - Back-to-back service of two ports: 2 cycles of overhead between L2 transactions.
- Live input changes during BUSY (withdrawn request, address change) are ignored; the captured transaction completes.
- L2_resp outside BUSY is ignored; no port_resp is generated.
- Read and write high together on one port is a protocol violation: both are captured and forwarded as-is, and a simulation assertion fires.
- Fairness: with all ports requesting continuously, grants rotate 0,1,..,N-1,0,...; no port waits more than N-1 transactions.
- NUM_PORTS = 1 degenerates to a pass-through with the GAP cycle retained.

Optional Feature:
- ARB_FIXED_PRIORITY_EN defined:
  - Lowest-index requesting port always wins.
  - rr_ptr register is removed.
  - Fairness guarantee is dropped; port 0 can starve the others.
- Undefined (default): round-robin behaviour as above.

Decomposition:
- Package arb_pkg:
  - enum arb_state_t {IDLE, BUSY, GAP}.
  - Function clog2_min1 for grant_id width.
- Sub-module rr_picker (NUM_PORTS): combinational req vector + rr_ptr -> winner index and valid; holds the ARB_FIXED_PRIORITY_EN switch.
- Top module holds the FSM, capture registers and response demux.

Test Plan:
- Single request: port 1 reads addr 0x0000_1000; L2 responds 3 cycles later with 0xA5 pattern -> L2_read high 1 cycle after request, port_resp = 0b10 with rdata 0xA5.., L2_read low in GAP.
- Contention, NUM_PORTS = 4: all ports request continuously; L2 answers each in 2 cycles -> grant_id sequence 0,1,2,3,0,1; port_resp pulses one-hot in that order.
- Input change mid-service: port 0 write to 0x40, then addr changes to 0x80 during BUSY -> L2_addr stays 0x40 until L2_resp.
- Async reset: assert rst in BUSY mid-transaction -> L2_read drops before the next edge; state IDLE; rr_ptr 0; the pending port is re-granted after reset release.
- Spurious L2_resp in IDLE with port 2 requesting -> no port_resp; port 2 is then granted normally.
- ARB_FIXED_PRIORITY_EN build: ports 0 and 3 requesting continuously -> port 0 is granted every time; port 3 only after port 0 drops its request.
